// File: rtl/pcs_stack.sv
// pcs_stack: program counter plus a DEPTH-entry circular return-address stack.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   stall       hold pc, stack and depth this cycle (err_clr still acts)
//   op          0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 RESTORE, 6-7 as SEQ
//   cond        branch condition, only used by BRANCH
//   target      absolute address (JUMP/CALL) or signed offset (BRANCH)
//   ra_restore  value written to the stack top by RESTORE
//   err_clr     clears the sticky overflow/underflow flags
//   pc          registered program counter
//   pc_1        pc + 1 (combinational)
//   ra          stack top, 0 when the stack is empty
//   depth       number of valid stack entries
//   overflow    sticky: CALL issued while the stack was full
//   underflow   sticky: RET issued while the stack was empty
module pcs_stack #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [2:0]               op,
  input  logic                     cond,
  input  logic [WIDTH-1:0]         target,
  input  logic [WIDTH-1:0]         ra_restore,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_1,
  output logic [WIDTH-1:0]         ra,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0]      FULL   = (PW+1)'(DEPTH);
  localparam logic [PW:0]      ONE_D  = (PW+1)'(1);
  localparam logic [PW-1:0]    ONE_P  = PW'(1);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  typedef enum logic [2:0] {
    OP_SEQ     = 3'd0,
    OP_JUMP    = 3'd1,
    OP_BRANCH  = 3'd2,
    OP_CALL    = 3'd3,
    OP_RET     = 3'd4,
    OP_RESTORE = 3'd5
  } op_e;

  logic [WIDTH-1:0] pc_q;
  logic [PW:0]      depth_q;
  logic [PW-1:0]    top_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] next_pc;
  logic [PW:0]      next_depth;
  logic [PW-1:0]    next_top;
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             set_ovf;
  logic             set_unf;

  assign pc    = pc_q;
  assign pc_1  = pc_q + ONE_W;
  assign depth = depth_q;
  assign ra    = (depth_q == '0) ? '0 : mem[top_ptr];

  // Next-state decode. top_ptr always indexes the newest entry; a push
  // pre-increments it, so a push while full lands on the oldest entry.
  always_comb begin
    next_pc    = pc_q;
    next_depth = depth_q;
    next_top   = top_ptr;
    mem_we     = 1'b0;
    mem_waddr  = top_ptr;
    mem_wdata  = ra_restore;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (!stall) begin
      next_pc = pc_1;
      case (op)
        OP_JUMP: next_pc = target;
        // Two's-complement offset: plain modular add covers both signs.
        OP_BRANCH: if (cond) next_pc = pc_q + target;
        OP_CALL: begin
          next_pc   = target;
          next_top  = top_ptr + ONE_P;
          mem_we    = 1'b1;
          mem_waddr = top_ptr + ONE_P;
          mem_wdata = pc_1;
          if (depth_q == FULL) set_ovf = 1'b1;
          else                 next_depth = depth_q + ONE_D;
        end
        OP_RET: begin
          if (depth_q != '0) begin
            next_pc    = ra;
            next_top   = top_ptr - ONE_P;
            next_depth = depth_q - ONE_D;
          end else begin
            set_unf = 1'b1;
          end
        end
        OP_RESTORE: begin
          mem_we = 1'b1;
          if (depth_q == '0) begin
            next_top   = top_ptr + ONE_P;
            mem_waddr  = top_ptr + ONE_P;
            next_depth = ONE_D;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural state; an error event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      depth_q   <= '0;
      top_ptr   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc_q      <= next_pc;
      depth_q   <= next_depth;
      top_ptr   <= next_top;
      overflow  <= set_ovf | (overflow & ~err_clr);
      underflow <= set_unf | (underflow & ~err_clr);
    end
  end

  // Stack storage carries no reset; entries beyond depth are never observed.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
